// File: rtl/mod_seq.sv
// mod_seq: sequential remainder unit, rem = a % b, using normalised
// shift-subtract. Two prio_enc instances give the MSB index of the latched
// dividend and divisor to set the initial alignment shift.
// Optional build macro: MOD_SEQ_EARLY_EXIT_EN (leave SUB as soon as the
// partial remainder drops below the divisor; results are unchanged).

// Priority encoder: index of the highest set bit (0 when input is zero).
module prio_enc #(
    parameter int unsigned WIDTH = 16
) (
    input  logic [WIDTH-1:0] in,
    output logic [7:0]       msb
);

    // Scan upward so the last set bit found is the most significant one.
    always_comb begin
        msb = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (in[i]) msb = 8'(i);
        end
    end

endmodule

module mod_seq #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             go,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             rdy,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] rem
);

    typedef enum logic [1:0] {
        IDLE,
        ALIGN,
        SUB,
        DONE
    } state_t;

    state_t           state, state_nxt;

    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] r;
    logic [WIDTH-1:0] d;
    logic [7:0]       cnt;

    logic [7:0]       msb_a;
    logic [7:0]       msb_b;
    logic [7:0]       shamt;
    logic [WIDTH-1:0] r_next;
    logic             early;
    logic             sub_last;

    prio_enc #(.WIDTH(WIDTH)) u_enc_a (
        .in  (a_r),
        .msb (msb_a)
    );

    prio_enc #(.WIDTH(WIDTH)) u_enc_b (
        .in  (b_r),
        .msb (msb_b)
    );

    // Alignment shift and the per-step subtract result.
    always_comb begin
        shamt  = msb_a - msb_b;
        r_next = (r >= d) ? (r - d) : r;
`ifdef MOD_SEQ_EARLY_EXIT_EN
        early  = (r_next < b_r);
`else
        early  = 1'b0;
`endif
        sub_last = (cnt == '0) || early;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (go) state_nxt = ALIGN;
            end
            ALIGN: begin
                if ((b_r == '0) || (a_r < b_r)) state_nxt = DONE;
                else                            state_nxt = SUB;
            end
            SUB: begin
                if (sub_last) state_nxt = DONE;
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs decoded from the current state.
    always_comb begin
        rdy  = (state == IDLE);
        done = (state == DONE);
    end

    // Datapath: operand latch, alignment, shift-subtract steps, result.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_r <= '0;
            b_r <= '0;
            r   <= '0;
            d   <= '0;
            cnt <= '0;
            rem <= '0;
            err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (go) begin
                        a_r <= a;
                        b_r <= b;
                        r   <= a;
                        err <= 1'b0;
                    end
                end
                ALIGN: begin
                    if (b_r == '0) begin
                        err <= 1'b1;
                        rem <= a_r;
                    end else if (a_r < b_r) begin
                        rem <= a_r;
                    end else begin
                        // msb(d) equals msb(a_r), so the shift never overflows.
                        d   <= b_r << shamt;
                        cnt <= shamt;
                    end
                end
                SUB: begin
                    r <= r_next;
                    d <= d >> 1;
                    if (sub_last) rem <= r_next;
                    else          cnt <= cnt - 8'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mod_seq.sv
// Testbench for mod_seq: scoreboard of expected rem/err/latency pushed at
// each accepted go and compared when done pulses.
module tb_mod_seq;

    localparam int unsigned W = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         go  = 1'b0;
    logic [W-1:0] a   = '0;
    logic [W-1:0] b   = '0;
    logic         rdy;
    logic         done;
    logic         err;
    logic [W-1:0] rem;

    typedef struct {
        logic [W-1:0] rem;
        logic         err;
        int           lat;
    } exp_t;

    exp_t q[$];

    int checks   = 0;
    int errors   = 0;
    int tick     = 0;
    int t0       = 0;
    int lat      = 0;
    int dones    = 0;
    int accepted = 0;

    mod_seq #(.WIDTH(W)) dut (
        .clk  (clk),
        .rst  (rst),
        .go   (go),
        .a    (a),
        .b    (b),
        .rdy  (rdy),
        .done (done),
        .err  (err),
        .rem  (rem)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        tick <= tick + 1;
        if (!rst && done) dones <= dones + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int msb_of(input logic [W-1:0] v);
        int m = 0;
        for (int i = 0; i < int'(W); i++) if (v[i]) m = i;
        return m;
    endfunction

    // Wait for rdy, present one go; returns with the bench in cycle 1.
    task automatic start_op(input logic [W-1:0] av, input logic [W-1:0] bv, input bit track);
        exp_t e;
        int   n = 0;
        while (!rdy && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (!rdy) check("rdy_timeout", 0, 1);
        a  = av;
        b  = bv;
        go = 1'b1;
        t0 = tick;
        if (track) begin
            e.err = (bv == '0);
            e.rem = (bv == '0) ? av : av % bv;
            e.lat = (bv == '0 || av < bv) ? 2 : 3 + msb_of(av) - msb_of(bv);
            q.push_back(e);
            accepted++;
        end
        @(posedge clk); #1;
        go = 1'b0;
        a  = $urandom;
        b  = $urandom;
    endtask

    // Wait for done and compare against the oldest scoreboard entry.
    task automatic wait_done();
        exp_t e;
        int   n = 0;
        while (!done && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        lat = tick - t0;
        if (q.size() == 0) begin
            check("sb_empty", 1, 0);
        end else begin
            e = q.pop_front();
            if (!done) begin
                check("done_timeout", 0, 1);
            end else begin
                check("rem", rem, e.rem);
                check("err", err, e.err);
`ifdef MOD_SEQ_EARLY_EXIT_EN
                check("lat_bound", (lat <= e.lat) ? 1 : 0, 1);
`else
                check("lat", lat, e.lat);
`endif
            end
        end
    endtask

    initial begin
        logic [W-1:0] ra, rb;

        repeat (2) @(posedge clk);
        #1;
        check("rst_rdy", rdy, 1);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_rem", rem, 0);
        rst = 1'b0;

        // a=100, b=7: s=4
        start_op(16'd100, 16'd7, 1);
        wait_done();
`ifdef MOD_SEQ_EARLY_EXIT_EN
        check("lat_100_7", lat, 6);
`else
        check("lat_100_7", lat, 7);
`endif

        // Reset held two cycles in the middle of SUB drops the request.
        start_op(16'hFFFF, 16'd1, 0);
        repeat (4) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        repeat (2) begin
            @(posedge clk); #1;
        end
        check("midrst_rdy", rdy, 1);
        check("midrst_done", done, 0);
        check("midrst_rem", rem, 0);
        check("midrst_err", err, 0);
        rst = 1'b0;

        start_op(16'd5, 16'd9, 1);
        wait_done();
        start_op(16'd0, 16'd0, 1);
        wait_done();
        start_op(16'hFFFF, 16'd1, 1);
        wait_done();
        start_op(16'hFFFF, 16'hFFFF, 1);
        wait_done();
        start_op(16'd1234, 16'd1234, 1);
        wait_done();

        // go pulsed while busy must be ignored.
        start_op(16'd100, 16'd7, 1);
        @(posedge clk); #1;
        a  = 16'd3;
        b  = 16'd2;
        go = 1'b1;
        @(posedge clk); #1;
        go = 1'b0;
        wait_done();

        // Back-to-back: go on the first rdy cycle after done.
        @(posedge clk); #1;
        check("rdy_after_done", rdy, 1);
        start_op(16'd5, 16'd9, 1);
        wait_done();
        @(posedge clk); #1;
        start_op(16'd1000, 16'd3, 1);
        wait_done();

        for (int i = 0; i < 3000; i++) begin
            ra = 16'($urandom);
            case ($urandom_range(0, 7))
                0:       rb = '0;
                1, 2:    rb = 16'($urandom_range(1, 15));
                3:       rb = 16'($urandom_range(16, 255));
                default: rb = 16'($urandom);
            endcase
            start_op(ra, rb, 1);
            wait_done();
        end

        @(posedge clk); #1;
        check("done_count", dones, accepted);
        check("sb_drained", q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
